// File: rtl/boot_sender_if.sv
// Boot-link bundle between boot_sender and its environment: session control,
// UART rx/tx byte ports and the word fetch port.
interface boot_sender_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] prog_words;
  logic [ADDR_W-1:0] data_words;
  logic              rx_ready;
  logic [7:0]        rdata;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        sdata;
  logic              fetch_req;
  logic              fetch_sel;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_data;
  logic              busy;
  logic              done;
  logic              error;

  // Sender side
  modport master (
    input  start, prog_words, data_words, rx_ready, rdata, tx_busy, fetch_ack, fetch_data,
    output tx_start, sdata, fetch_req, fetch_sel, fetch_addr, busy, done, error
  );

  // Environment side: UART, word memory and session controller
  modport slave (
    output start, prog_words, data_words, rx_ready, rdata, tx_busy, fetch_ack, fetch_data,
    input  tx_start, sdata, fetch_req, fetch_sel, fetch_addr, busy, done, error
  );
endinterface

// File: rtl/boot_sender.sv
// Host-side boot server: waits for the loader beacon, streams size and program words,
// waits for the ack, then streams data words. BOOT_SENDER_TIMEOUT_EN adds a WAIT_AA timeout.
module boot_sender #(
  parameter int unsigned ADDR_W = 16
`ifdef BOOT_SENDER_TIMEOUT_EN
  , parameter int unsigned AA_TIMEOUT = 32'd1 << 20
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  boot_sender_if.master io_bus
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_99,
    S_SEND_SIZE,
    S_FETCH_P,
    S_SEND_P,
    S_WAIT_AA,
    S_FETCH_D,
    S_SEND_D,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_prog_words;
  logic [ADDR_W-1:0] r_data_words;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sel;
  logic              r_fetch_req;
  logic              r_tx_start;
  logic [7:0]        r_sdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
`ifdef BOOT_SENDER_TIMEOUT_EN
  logic [31:0]       r_to_cnt;
  logic [31:0]       w_to_cnt_nxt;
`endif

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_prog_nxt;
  logic [ADDR_W-1:0] w_data_nxt;
  logic [31:0]       w_word_nxt;
  logic [1:0]        w_idx_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_sel_nxt;
  logic              w_req_nxt;
  logic              w_tx_start_nxt;
  logic [7:0]        w_sdata_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_error_nxt;
  logic              w_issue;
  logic              w_fail;
  logic              w_finish;

  logic              w_rx_99;
  logic              w_rx_aa;
  logic              w_can_send;
  logic              w_last_byte;
  logic              w_last_p;
  logic              w_last_d;
  logic [7:0]        w_byte;
  logic [31:0]       w_size;

  assign w_rx_99     = io_bus.rx_ready && (io_bus.rdata == 8'h99);
  assign w_rx_aa     = io_bus.rx_ready && (io_bus.rdata == 8'haa);
  // r_tx_start blocks the cycle before the UART can raise tx_busy
  assign w_can_send  = !io_bus.tx_busy && !r_tx_start;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_byte      = r_word[{r_byte_idx, 3'b000} +: 8];
  assign w_size      = 32'(r_prog_words) << 2;
  assign w_last_p    = (CW'(r_addr) + CW'(1)) == CW'(r_prog_words);
  assign w_last_d    = (CW'(r_addr) + CW'(1)) == CW'(r_data_words);

  // State and output register bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_prog_words <= '0;
      r_data_words <= '0;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_addr       <= '0;
      r_sel        <= 1'b0;
      r_fetch_req  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_sdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef BOOT_SENDER_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_prog_words <= w_prog_nxt;
      r_data_words <= w_data_nxt;
      r_word       <= w_word_nxt;
      r_byte_idx   <= w_idx_nxt;
      r_addr       <= w_addr_nxt;
      r_sel        <= w_sel_nxt;
      r_fetch_req  <= w_req_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_sdata      <= w_sdata_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
`ifdef BOOT_SENDER_TIMEOUT_EN
      r_to_cnt     <= w_to_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_prog_nxt     = r_prog_words;
    w_data_nxt     = r_data_words;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_byte_idx;
    w_addr_nxt     = r_addr;
    w_sel_nxt      = r_sel;
    w_req_nxt      = r_fetch_req;
    w_tx_start_nxt = 1'b0;
    w_sdata_nxt    = r_sdata;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_issue        = 1'b0;
    w_fail         = 1'b0;
    w_finish       = 1'b0;
`ifdef BOOT_SENDER_TIMEOUT_EN
    w_to_cnt_nxt   = (r_state == S_WAIT_AA) ? r_to_cnt + 32'd1 : 32'd0;
`endif

    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (io_bus.start) begin
          w_state_nxt = S_WAIT_99;
          w_prog_nxt  = io_bus.prog_words;
          w_data_nxt  = io_bus.data_words;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_addr_nxt  = '0;
          w_idx_nxt   = 2'd0;
          w_sel_nxt   = 1'b0;
        end
      end

      S_WAIT_99: begin
        if (w_rx_99) begin
          w_state_nxt = S_SEND_SIZE;
          w_word_nxt  = w_size;
          w_idx_nxt   = 2'd0;
        end
      end

      S_SEND_SIZE: begin
        if (w_rx_aa) begin
          w_fail = 1'b1;
        end else if (w_can_send) begin
          w_issue = 1'b1;
          if (w_last_byte) begin
            if (r_prog_words == '0) begin
              w_state_nxt = S_WAIT_AA;
            end else begin
              w_state_nxt = S_FETCH_P;
              w_req_nxt   = 1'b1;
              w_addr_nxt  = '0;
            end
          end
        end
      end

      S_FETCH_P: begin
        if (w_rx_aa) begin
          w_fail = 1'b1;
        end else if (io_bus.fetch_ack) begin
          w_word_nxt  = io_bus.fetch_data;
          w_req_nxt   = 1'b0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SEND_P;
        end
      end

      S_SEND_P: begin
        if (w_rx_aa) begin
          w_fail = 1'b1;
        end else if (w_can_send) begin
          w_issue = 1'b1;
          if (w_last_byte) begin
            if (w_last_p) begin
              w_state_nxt = S_WAIT_AA;
              w_addr_nxt  = '0;
            end else begin
              w_state_nxt = S_FETCH_P;
              w_req_nxt   = 1'b1;
              w_addr_nxt  = r_addr + ADDR_W'(1);
            end
          end
        end
      end

      S_WAIT_AA: begin
        if (w_rx_aa) begin
          if (r_data_words == '0) begin
            w_finish = 1'b1;
          end else begin
            w_state_nxt = S_FETCH_D;
            w_sel_nxt   = 1'b1;
            w_addr_nxt  = '0;
            w_req_nxt   = 1'b1;
          end
        end else if (io_bus.rx_ready && !w_rx_99) begin
          w_fail = 1'b1;
        end
`ifdef BOOT_SENDER_TIMEOUT_EN
        else if (r_to_cnt == 32'(AA_TIMEOUT - 1)) begin
          w_fail = 1'b1;
        end
`endif
      end

      S_FETCH_D: begin
        if (io_bus.fetch_ack) begin
          w_word_nxt  = io_bus.fetch_data;
          w_req_nxt   = 1'b0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SEND_D;
        end
      end

      S_SEND_D: begin
        if (w_can_send) begin
          w_issue = 1'b1;
          if (w_last_byte) begin
            if (w_last_d) begin
              w_finish = 1'b1;
            end else begin
              w_state_nxt = S_FETCH_D;
              w_req_nxt   = 1'b1;
              w_addr_nxt  = r_addr + ADDR_W'(1);
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_issue) begin
      w_tx_start_nxt = 1'b1;
      w_sdata_nxt    = w_byte;
      w_idx_nxt      = r_byte_idx + 2'd1;
    end

    if (w_finish) begin
      w_state_nxt = S_DONE;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b1;
    end

    if (w_fail) begin
      w_state_nxt = S_ERROR;
      w_busy_nxt  = 1'b0;
      w_error_nxt = 1'b1;
      w_req_nxt   = 1'b0;
    end
  end

  assign io_bus.tx_start   = r_tx_start;
  assign io_bus.sdata      = r_sdata;
  assign io_bus.fetch_req  = r_fetch_req;
  assign io_bus.fetch_sel  = r_sel;
  assign io_bus.fetch_addr = r_addr;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.error      = r_error;

endmodule

// File: tb/tb_boot_sender.sv
// Scoreboard bench for boot_sender: expected tx bytes are queued as each session is
// set up and popped as the UART model sees tx_start.
module tb_boot_sender;

  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boot_sender_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef BOOT_SENDER_TIMEOUT_EN
  boot_sender #(.ADDR_W(ADDR_W), .AA_TIMEOUT(100)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.master)
  );
`else
  boot_sender #(.ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.master)
  );
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          busy_len = 1;
  int          fetch_delay = 0;
  int          n_tx = 0;
  int          n_req_cycles = 0;
  int          n_overlap = 0;
  int          n_unstable = 0;
  int          n_extra = 0;
  logic [31:0] prog_mem[16];
  logic [31:0] data_mem[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: tx_busy rises one cycle after tx_start, stays up busy_len cycles
  initial begin
    logic       tx_pend;
    int         busy_cnt;
    logic [7:0] last_sdata;
    tx_pend    = 1'b0;
    busy_cnt   = 0;
    last_sdata = 8'h00;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) last_sdata = 8'h00;
      if (bus.tx_start) begin
        if (tx_pend || bus.tx_busy) n_overlap++;
        n_tx++;
        last_sdata = bus.sdata;
        if (exp_q.size() == 0) n_extra++;
        else check("tx_byte", 32'(bus.sdata), 32'(exp_q.pop_front()));
        tx_pend = 1'b1;
      end else begin
        if (rst_n && bus.sdata !== last_sdata) n_unstable++;
        if (tx_pend) begin
          tx_pend = 1'b0;
          if (busy_len > 0) begin
            bus.tx_busy = 1'b1;
            busy_cnt    = busy_len;
          end
        end else if (bus.tx_busy) begin
          busy_cnt--;
          if (busy_cnt <= 0) bus.tx_busy = 1'b0;
        end
      end
    end
  end

  // Word memory model: acknowledges a request fetch_delay cycles after it is seen
  initial begin
    int fwait;
    fwait = 0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.fetch_req) n_req_cycles++;
      if (bus.fetch_ack) begin
        bus.fetch_ack = 1'b0;
      end else if (bus.fetch_req) begin
        if (fwait >= fetch_delay) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = bus.fetch_sel ? data_mem[bus.fetch_addr[3:0]]
                                         : prog_mem[bus.fetch_addr[3:0]];
          fwait = 0;
        end else begin
          fwait++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rdata    = b;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.rdata    = 8'h00;
  endtask

  task automatic start_session(input int pw, input int dw);
    bus.prog_words = ADDR_W'(pw);
    bus.data_words = ADDR_W'(dw);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.prog_words = '1;
    bus.data_words = '1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_ntx(input string tag, input int n, input int budget);
    int k = 0;
    while (n_tx < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n_tx >= n), 32'd1);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (!(bus.done || bus.error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.done || bus.error), 32'd1);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
    check({tag, "_sdata"},      32'(bus.sdata),      32'd0);
    check({tag, "_fetch_req"},  32'(bus.fetch_req),  32'd0);
    check({tag, "_fetch_addr"}, 32'(bus.fetch_addr), 32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_error"},      32'(bus.error),      32'd0);
  endtask

  task automatic check_link(input string tag);
    check({tag, "_overlap"},  n_overlap,  0);
    check({tag, "_unstable"}, n_unstable, 0);
    check({tag, "_extra"},    n_extra,    0);
  endtask

  initial begin
    int base;
    bus.start      = 1'b0;
    bus.prog_words = '0;
    bus.data_words = '0;
    bus.rx_ready   = 1'b0;
    bus.rdata      = 8'h00;
    for (int i = 0; i < 16; i++) begin
      prog_mem[i] = 32'h0;
      data_mem[i] = 32'h0;
    end
    prog_mem[0] = 32'h11223344;
    prog_mem[1] = 32'h55667788;
    prog_mem[2] = 32'h0badf00d;
    data_mem[0] = 32'hdeadbeef;
    data_mem[1] = 32'hcafe0123;

    repeat (3) @(negedge clk);
    check_outputs_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic session: 2 program words, 1 data word
    busy_len = 3; fetch_delay = 1;
    start_session(2, 1);
    push_word(32'd8); push_word(prog_mem[0]); push_word(prog_mem[1]);
    repeat (3) @(negedge clk);
    rx_byte(8'h12);
    rx_byte(8'h99);
    wait_drain("t1_prog", 400);
    push_word(data_mem[0]);
    rx_byte(8'haa);
    wait_drain("t1_data", 200);
    wait_end("t1_end", 50);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_error", 32'(bus.error), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check_link("t1");

    // Repeated beacons, the third during the size bytes
    busy_len = 5; fetch_delay = 0;
    start_session(1, 0);
    push_word(32'd4); push_word(prog_mem[0]);
    rx_byte(8'h99);
    base = n_tx;
    wait_ntx("t2_first", base + 1, 100);
    rx_byte(8'h99);
    wait_ntx("t2_second", base + 2, 100);
    rx_byte(8'h99);
    wait_drain("t2_prog", 400);
    rx_byte(8'haa);
    wait_end("t2_end", 50);
    check("t2_done", 32'(bus.done), 32'd1);
    repeat (10) @(negedge clk);
    check_link("t2");

    // Empty program and data
    busy_len = 2;
    n_req_cycles = 0;
    start_session(0, 0);
    push_word(32'd0);
    rx_byte(8'h99);
    wait_drain("t3_size", 200);
    rx_byte(8'haa);
    wait_end("t3_end", 50);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_no_fetch", n_req_cycles, 0);
    check_link("t3");

    // Slow UART and slow memory, stray start mid-session
    busy_len = 50; fetch_delay = 7;
    start_session(3, 2);
    push_word(32'd12);
    for (int i = 0; i < 3; i++) push_word(prog_mem[i]);
    rx_byte(8'h99);
    wait_ntx("t4_started", n_tx + 2, 300);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4_busy_kept", 32'(bus.busy), 32'd1);
    wait_drain("t4_prog", 3000);
    for (int i = 0; i < 2; i++) push_word(data_mem[i]);
    rx_byte(8'haa);
    wait_drain("t4_data", 2000);
    wait_end("t4_end", 200);
    check("t4_done", 32'(bus.done), 32'd1);
    check_link("t4");

    // Bad byte while waiting for the ack, then recovery
    busy_len = 1; fetch_delay = 0;
    start_session(1, 1);
    push_word(32'd4); push_word(prog_mem[0]);
    rx_byte(8'h99);
    wait_drain("t5_prog", 200);
    repeat (2) @(negedge clk);
    rx_byte(8'h5a);
    check("t5_error", 32'(bus.error), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    start_session(1, 1);
    check("t5_error_clr", 32'(bus.error), 32'd0);
    push_word(32'd4); push_word(prog_mem[0]);
    rx_byte(8'h99);
    wait_drain("t5_prog2", 200);
    push_word(data_mem[0]);
    rx_byte(8'haa);
    wait_drain("t5_data", 200);
    wait_end("t5_end", 50);
    check("t5_done2", 32'(bus.done), 32'd1);

    // Ack arriving while the size is still being sent
    start_session(2, 0);
    push_word(32'd8); push_word(prog_mem[0]); push_word(prog_mem[1]);
    rx_byte(8'h99);
    base = n_tx;
    wait_ntx("t5b_two", base + 2, 100);
    rx_byte(8'haa);
    check("t5b_error", 32'(bus.error), 32'd1);
    check("t5b_no_req", 32'(bus.fetch_req), 32'd0);
    base = n_tx;
    repeat (20) @(negedge clk);
    check("t5b_quiet", n_tx, base);
    exp_q.delete();
    check_link("t5");

    // Asynchronous reset in the middle of a program word
    busy_len = 4;
    start_session(2, 0);
    push_word(32'd8); push_word(prog_mem[0]); push_word(prog_mem[1]);
    rx_byte(8'h99);
    base = n_tx;
    wait_ntx("t6_bytes", base + 6, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_reset("t6");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check_link("t6");

`ifdef BOOT_SENDER_TIMEOUT_EN
    // Ack never arrives
    begin
      int k;
      busy_len = 1;
      start_session(0, 0);
      push_word(32'd0);
      rx_byte(8'h99);
      wait_drain("t7_size", 200);
      k = 0;
      while (!bus.error && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("t7_error", 32'(bus.error), 32'd1);
      check("t7_cycles", k, 100);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
